// File: rtl/ram_sync_dp.sv
// Synchronous simple-dual-port RAM with byte enables, 1- or 2-cycle read latency,
// selectable read-during-write policy, range checking and a hardware clear sequencer.
module ram_sync_dp #(
  parameter int unsigned addr_size   = 4,
  parameter int unsigned word_size   = 16,
  parameter int unsigned memory_size = 12,
  parameter int unsigned rd_latency  = 1,
  parameter int unsigned write_first = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cs,
  input  logic                   clr,
  input  logic                   wr,
  input  logic [addr_size-1:0]   wr_addr,
  input  logic [word_size-1:0]   wr_data,
  input  logic [word_size/8-1:0] wr_be,
  input  logic                   rd,
  input  logic [addr_size-1:0]   rd_addr,
  output logic [word_size-1:0]   rd_data,
  output logic                   rd_valid,
  output logic                   err,
  output logic                   init_busy
);

  localparam int unsigned BE_W = word_size / 8;
  localparam int unsigned AW1  = addr_size + 1;
  localparam logic [AW1-1:0]       MEM_WORDS = AW1'(memory_size);
  localparam logic [addr_size-1:0] CNT_LAST  = addr_size'(memory_size - 1);
  localparam bit                   WF        = (write_first != 0);

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [addr_size-1:0] cnt_q, cnt_d;
  logic                 clear_we_c;

  logic [word_size-1:0] mem [memory_size];

  // State register; init_busy tracks the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= '0;
      init_busy <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      init_busy <= (state_d == ST_CLEAR);
    end
  end

  // Next-state logic; clr during CLEAR is deliberately ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (cnt_q == CNT_LAST) state_d = ST_READY;
      ST_READY: if (clr)               state_d = ST_CLEAR;
      default:                         state_d = ST_CLEAR;
    endcase
  end

  // Clear sequencer controls
  always_comb begin
    clear_we_c = 1'b0;
    cnt_d      = '0;
    case (state_q)
      ST_CLEAR: begin
        clear_we_c = 1'b1;
        cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + addr_size'(1);
      end
      default: cnt_d = '0;
    endcase
  end

  // Access decode
  logic ready_c, wr_in_c, rd_in_c, wr_acc_c, rd_acc_c, wr_do_c, err_c, collide_c;
  logic [word_size-1:0] old_word_c, new_word_c, rd_word_c;

  always_comb begin
    ready_c   = (state_q == ST_READY);
    wr_in_c   = {1'b0, wr_addr} < MEM_WORDS;
    rd_in_c   = {1'b0, rd_addr} < MEM_WORDS;
    wr_acc_c  = ready_c & cs & wr;
    rd_acc_c  = ready_c & cs & rd;
    wr_do_c   = wr_acc_c & wr_in_c;
    err_c     = (cs & (rd | wr) & ~ready_c) | (wr_acc_c & ~wr_in_c) | (rd_acc_c & ~rd_in_c);
    collide_c = wr_do_c & (wr_addr == rd_addr);
    old_word_c = rd_in_c ? mem[rd_addr] : '0;
    new_word_c = old_word_c;
    for (int i = 0; i < int'(BE_W); i++) begin
      if (wr_be[i]) new_word_c[8*i +: 8] = wr_data[8*i +: 8];
    end
    rd_word_c = (WF && collide_c) ? new_word_c : old_word_c;
  end

  // Storage array: no reset, zeroed by the clear sequencer
  always_ff @(posedge clk) begin
    if (clear_we_c) begin
      mem[cnt_q] <= '0;
    end else if (wr_do_c) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= err_c;
  end

  // Read pipeline; rd_data only changes on a valid pulse
  generate
    if (rd_latency == 2) begin : g_lat2
      logic                 s1_valid;
      logic [word_size-1:0] s1_data;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_valid <= 1'b0;
          s1_data  <= '0;
          rd_valid <= 1'b0;
          rd_data  <= '0;
        end else begin
          s1_valid <= rd_acc_c;
          if (rd_acc_c) s1_data <= rd_word_c;
          rd_valid <= s1_valid;
          if (s1_valid) rd_data <= s1_data;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_valid <= 1'b0;
          rd_data  <= '0;
        end else begin
          rd_valid <= rd_acc_c;
          if (rd_acc_c) rd_data <= rd_word_c;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_ram_sync_dp.sv
// Scoreboard bench for ram_sync_dp: two instances (latency 1 / write-first and
// latency 2 / read-first) driven with the same stimulus against an array model.
module tb_ram_sync_dp;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned M  = 12;
  localparam int unsigned BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cs = 1'b0, clr = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [BW-1:0] wr_be = '0;

  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          rd_valid_a, rd_valid_b, err_a, err_b, busy_a, busy_b;

  always #5 clk = ~clk;

  ram_sync_dp #(.addr_size(AW), .word_size(DW), .memory_size(M), .rd_latency(1), .write_first(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .cs(cs), .clr(clr), .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd(rd), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .err(err_a), .init_busy(busy_a));

  ram_sync_dp #(.addr_size(AW), .word_size(DW), .memory_size(M), .rd_latency(2), .write_first(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .cs(cs), .clr(clr), .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd(rd), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .err(err_b), .init_busy(busy_b));

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          qa[$], qb[$];
  logic [DW-1:0] mem_m [M];
  logic [DW-1:0] last_a = '0, last_b = '0;
  int            busy_left = M;
  int            cyc = 0;
  bit            exp_err = 1'b0, exp_busy = 1'b1;
  int            n_checks = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old);
    logic [DW-1:0] r = old;
    for (int i = 0; i < int'(BW); i++)
      if (wr_be[i]) r[8*i +: 8] = wr_data[8*i +: 8];
    return r;
  endfunction

  // Reference model: one call per rising edge, using the inputs about to be sampled
  task automatic model_edge();
    bit            ready, e;
    logic [DW-1:0] old, nw;
    exp_t          x;
    if (!rst_n) begin
      exp_err  = 1'b0;
      exp_busy = 1'b1;
      return;
    end
    ready = (busy_left == 0);
    e = cs && (rd || wr) && !ready;
    if (ready && cs && rd) begin
      if (int'(rd_addr) >= int'(M)) begin
        e = 1'b1;
        old = '0;
        nw  = '0;
      end else begin
        old = mem_m[rd_addr];
        nw  = (wr && wr_addr == rd_addr) ? merge(old) : old;
      end
      x.due = cyc + 1; x.data = nw;  qa.push_back(x);
      x.due = cyc + 2; x.data = old; qb.push_back(x);
    end
    if (ready && cs && wr) begin
      if (int'(wr_addr) >= int'(M)) e = 1'b1;
      else mem_m[wr_addr] = merge(mem_m[wr_addr]);
    end
    if (!ready) busy_left--;
    else if (clr) begin
      busy_left = M;
      for (int i = 0; i < int'(M); i++) mem_m[i] = '0;
    end
    exp_err  = e;
    exp_busy = (busy_left > 0);
  endtask

  task automatic step();
    model_edge();
    @(negedge clk);
  endtask

  task automatic io(input bit c, input bit cl, input bit w, input int wa, input logic [DW-1:0] wd,
                    input logic [BW-1:0] be, input bit r, input int ra);
    cs = c; clr = cl; wr = w; wr_addr = AW'(wa); wr_data = wd; wr_be = be; rd = r; rd_addr = AW'(ra);
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) io(0, 0, 0, 0, '0, '0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    cs = 0; clr = 0; wr = 0; rd = 0;
    #1;
    check("reset_rd_valid_b", rd_valid_b, 0);
    check("reset_rd_data_b", rd_data_b, 0);
    check("reset_rd_valid_a", rd_valid_a, 0);
    check("reset_err", err_a | err_b, 0);
    check("reset_init_busy", busy_a & busy_b, 1);
    qa.delete(); qb.delete();
    last_a = '0; last_b = '0;
    for (int i = 0; i < int'(M); i++) mem_m[i] = '0;
    busy_left = M;
    exp_err = 1'b0; exp_busy = 1'b1;
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  // Monitor: per-port scoreboard pop plus per-cycle flag checks
  task automatic mon_port(input bit b, input logic v, input logic [DW-1:0] d);
    exp_t e;
    bit   have, late;
    have = b ? (qb.size() > 0) : (qa.size() > 0);
    late = have && (b ? (qb[0].due <= cyc) : (qa[0].due <= cyc));
    if (v) begin
      if (!have) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_rd_valid port %0d at cycle %0d: got 1 want 0", b, cyc);
      end else begin
        if (b) e = qb.pop_front(); else e = qa.pop_front();
        check(b ? "rd_latency_b" : "rd_latency_a", cyc, e.due);
        check(b ? "rd_data_b" : "rd_data_a", d, e.data);
        if (b) last_b = e.data; else last_a = e.data;
      end
    end else begin
      check(b ? "rd_data_hold_b" : "rd_data_hold_a", d, b ? last_b : last_a);
      if (late) begin
        n_checks++; n_fail++;
        $display("FAIL missing_rd_valid port %0d at cycle %0d: got 0 want 1", b, cyc);
        if (b) void'(qb.pop_front()); else void'(qa.pop_front());
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      mon_port(1'b0, rd_valid_a, rd_data_a);
      mon_port(1'b1, rd_valid_b, rd_data_b);
      check("err_a", err_a, exp_err);
      check("err_b", err_b, exp_err);
      check("init_busy_a", busy_a, exp_busy);
      check("init_busy_b", busy_b, exp_busy);
    end
  end

  initial begin
    #1;
    do_reset(2);
    idle(M);
    for (int a = 0; a < int'(M); a++) io(1, 0, 0, 0, '0, '0, 1, a);
    // Byte-merge at addr 3
    io(1, 0, 1, 3, 16'hBEEF, 2'b11, 0, 0);
    io(1, 0, 1, 3, 16'h1234, 2'b10, 0, 0);
    io(1, 0, 0, 0, '0, '0, 1, 3);
    io(1, 0, 1, 4, 16'h7777, 2'b00, 1, 4);
    // Read-during-write at addr 5
    io(1, 0, 1, 5, 16'h5555, 2'b11, 0, 0);
    io(1, 0, 1, 5, 16'hAAAA, 2'b11, 1, 5);
    io(1, 0, 0, 0, '0, '0, 1, 5);
    // Out of range on both ports, then cs=0 ignored
    io(1, 0, 1, 13, 16'hDEAD, 2'b11, 1, 14);
    io(0, 0, 1, 15, 16'hDEAD, 2'b11, 1, 15);
    io(1, 0, 0, 0, '0, '0, 1, 13);
    // Fill, clear with a read in flight, access while busy
    for (int a = 0; a < int'(M); a++) io(1, 0, 1, a, 16'hFFFF, 2'b11, 1, (a + 11) % M);
    io(1, 1, 1, 0, 16'h0F0F, 2'b01, 1, 0);
    io(1, 0, 0, 0, '0, '0, 1, 2);
    io(1, 1, 1, 3, 16'h1111, 2'b11, 0, 0);
    idle(M);
    for (int a = 0; a < int'(M); a++) io(1, 0, 0, 0, '0, '0, 1, a);
    // Randomized traffic
    repeat (600) begin
      io($urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0, 1'($urandom), $urandom_range(0, 15),
         DW'($urandom), BW'($urandom), 1'($urandom), $urandom_range(0, 15));
    end
    idle(M + 2);
    // Reset while a latency-2 read is in flight
    io(1, 0, 1, 2, 16'hC3C3, 2'b11, 0, 0);
    io(1, 0, 0, 0, '0, '0, 1, 2);
    do_reset(2);
    idle(M);
    for (int a = 0; a < 4; a++) io(1, 0, 0, 0, '0, '0, 1, a);
    idle(4);
    check("scoreboard_drained", qa.size() + qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
